// File: rtl/mem_port_arbiter_pkg.sv
// Shared requester IDs and default sizing for the inst/data memory port arbiter.
package mem_port_arbiter_pkg;
  typedef enum logic {
    ID_INST = 1'b0,
    ID_DATA = 1'b1
  } req_id_e;

  localparam int ADDR_W_DEF     = 32;
  localparam int OUT_DEPTH_DEF  = 2;
  localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/mem_port_arbiter_req_id_fifo.sv
// In-order queue of outstanding requester IDs; registered push/pop, read data is the head.
// Push is ignored when full and pop when empty; the caller gates both.
module req_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem_q[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one split-transaction memory port between inst and data requesters; zero added latency.
// Grants stall while OUT_DEPTH transactions are outstanding or the memory withholds addr_ok.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int OUT_DEPTH  = OUT_DEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [ADDR_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [ADDR_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [ADDR_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [ADDR_W-1:0] mem_rdata
);
  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  logic             lock_q;
  req_id_e          owner_q;
  logic [STV_W-1:0] starve_q;
  logic             win_vld;
  req_id_e          win_id;
  logic             addr_hs;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [0:0]       head_id;

  // Inst is only forced while it is still requesting; a saturated count can linger one cycle after inst_req drops.
  always_comb begin
    win_vld = 1'b0;
    win_id  = ID_INST;
    if (lock_q) begin
      win_vld = 1'b1;
      win_id  = owner_q;
    end else if (inst_req && (starve_q == STV_W'(STARVE_MAX))) begin
      win_vld = 1'b1;
      win_id  = ID_INST;
    end else if (data_req) begin
      win_vld = 1'b1;
      win_id  = ID_DATA;
    end else if (inst_req) begin
      win_vld = 1'b1;
      win_id  = ID_INST;
    end
  end

  assign mem_req      = resetn && win_vld && (fifo_count < CNT_W'(OUT_DEPTH));
  assign addr_hs      = mem_req && mem_addr_ok;
  assign inst_addr_ok = addr_hs && (win_id == ID_INST);
  assign data_addr_ok = addr_hs && (win_id == ID_DATA);

  always_comb begin
    mem_wr    = 1'b0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (resetn && win_vld) begin
      if (win_id == ID_DATA) begin
        mem_wr    = data_wr;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_addr  = inst_addr;
      end
    end
  end

  assign pop          = resetn && mem_data_ok && !fifo_empty;
  assign inst_data_ok = pop && (head_id == ID_INST);
  assign data_data_ok = pop && (head_id == ID_DATA);
  assign inst_rdata   = resetn ? mem_rdata : '0;
  assign data_rdata   = resetn ? mem_rdata : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q  <= 1'b0;
      owner_q <= ID_INST;
    end else if (addr_hs) begin
      lock_q  <= 1'b0;
    end else if (mem_req) begin
      lock_q  <= 1'b1;
      owner_q <= win_id;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
    end else if (!inst_req || inst_addr_ok) begin
      starve_q <= '0;
    end else if (starve_q != STV_W'(STARVE_MAX)) begin
      starve_q <= starve_q + STV_W'(1);
    end
  end

  req_id_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(1)) u_id_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (addr_hs),
    .push_dat (win_id),
    .pop      (pop),
    .pop_dat  (head_id),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  a_one_data_ok: assert property (@(posedge clk) disable iff (!resetn)
    !(inst_data_ok && data_data_ok));
  a_data_ok_outstanding: assert property (@(posedge clk) disable iff (!resetn)
    (inst_data_ok || data_data_ok) |-> !fifo_empty);
  a_full_count: assert property (@(posedge clk) disable iff (!resetn)
    fifo_full == (fifo_count == CNT_W'(OUT_DEPTH)));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with default parameters.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          inst_req, inst_addr_ok, inst_data_ok;
  logic [AW-1:0] inst_addr, inst_rdata;
  logic          data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]    data_wstrb;
  logic [AW-1:0] data_addr, data_wdata, data_rdata;
  logic          mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [3:0]    mem_wstrb;
  logic [AW-1:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    logic          id;
    logic [AW-1:0] addr;
    logic          wr;
    logic [3:0]    wstrb;
    logic [AW-1:0] wdata;
  } addr_exp_t;

  typedef struct {
    logic          id;
    logic [AW-1:0] rdata;
  } data_exp_t;

  addr_exp_t addr_q[$];
  data_exp_t data_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] onehot_id(input logic id);
    return id ? 32'd2 : 32'd1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
  endtask

  task automatic exp_addr(input logic id, input logic [AW-1:0] a, input logic wr,
                          input logic [3:0] s, input logic [AW-1:0] wd);
    addr_exp_t e;
    e.id = id; e.addr = a; e.wr = wr; e.wstrb = s; e.wdata = wd;
    addr_q.push_back(e);
  endtask

  task automatic exp_data(input logic id, input logic [AW-1:0] rd);
    data_exp_t e;
    e.id = id; e.rdata = rd;
    data_q.push_back(e);
  endtask

  // Monitor: every handshake the DUT presents must match the oldest expectation.
  initial begin
    addr_exp_t ea;
    data_exp_t ed;
    forever begin
      @(negedge clk);
      if (inst_addr_ok || data_addr_ok) begin
        if (addr_q.size() == 0) begin
          chk("unexpected_addr_ok", 32'({data_addr_ok, inst_addr_ok}), '0);
        end else begin
          ea = addr_q.pop_front();
          chk("addr_ok_id", 32'({data_addr_ok, inst_addr_ok}), onehot_id(ea.id));
          chk("mem_addr", mem_addr, ea.addr);
          chk("mem_wr_wstrb", 32'({mem_wr, mem_wstrb}), 32'({ea.wr, ea.wstrb}));
          chk("mem_wdata", mem_wdata, ea.wdata);
        end
      end
      if (inst_data_ok || data_data_ok) begin
        if (data_q.size() == 0) begin
          chk("unexpected_data_ok", 32'({data_data_ok, inst_data_ok}), '0);
        end else begin
          ed = data_q.pop_front();
          chk("data_ok_id", 32'({data_data_ok, inst_data_ok}), onehot_id(ed.id));
          chk("rdata", ed.id ? data_rdata : inst_rdata, ed.rdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic win_inst;
    resetn = 1'b1;
    clr_in();
    #1 resetn = 1'b0;
    // Requests and a stray data_ok while in reset must produce nothing.
    inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h0000_0100; mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1; mem_rdata = 32'hdead_beef;
    @(negedge clk);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), '0);
    chk("rst_data_ok", 32'({inst_data_ok, data_data_ok}), '0);
    chk("rst_rdata", inst_rdata | data_rdata, '0);
    cyc(); clr_in(); resetn = 1'b1;

    // Simultaneous requests: data wins.
    inst_req = 1'b1; inst_addr = 32'h0000_1000;
    data_req = 1'b1; data_addr = 32'h0000_2000; mem_addr_ok = 1'b1;
    exp_addr(ID_DATA, 32'h0000_2000, 1'b0, 4'h0, '0);
    @(negedge clk);
    chk1("t25_data_addr_ok", data_addr_ok, 1'b1);
    chk1("t25_inst_addr_ok", inst_addr_ok, 1'b0);
    chk("t25_mem_addr", mem_addr, 32'h0000_2000);
    cyc(); clr_in(); mem_data_ok = 1'b1; mem_rdata = 32'haaaa_5555;
    exp_data(ID_DATA, 32'haaaa_5555);
    cyc(); clr_in();

    // Inst locked in while memory withholds addr_ok; data request arrives meanwhile.
    inst_req = 1'b1; inst_addr = 32'h0000_3000;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hf;
        data_addr = 32'h0000_4000; data_wdata = 32'h1234_5678;
      end
      @(negedge clk);
      chk1("t27_mem_req", mem_req, 1'b1);
      chk("t27_mem_addr", mem_addr, 32'h0000_3000);
      chk1("t27_data_addr_ok", data_addr_ok, 1'b0);
      cyc();
    end
    mem_addr_ok = 1'b1;
    exp_addr(ID_INST, 32'h0000_3000, 1'b0, 4'h0, '0);
    @(negedge clk);
    chk1("t27_inst_hs", inst_addr_ok, 1'b1);
    cyc(); inst_req = 1'b0;
    exp_addr(ID_DATA, 32'h0000_4000, 1'b1, 4'hf, 32'h1234_5678);
    @(negedge clk);
    chk1("t27_mem_wr", mem_wr, 1'b1);
    cyc(); clr_in(); mem_data_ok = 1'b1; mem_rdata = 32'h1111_0000;
    exp_data(ID_INST, 32'h1111_0000);
    cyc(); mem_rdata = 32'h2222_0000;
    exp_data(ID_DATA, 32'h2222_0000);
    cyc(); clr_in();

    // Two outstanding fill the queue; third request waits for a pop plus one cycle.
    inst_req = 1'b1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1'b1;
    exp_addr(ID_INST, 32'h1c00_0000, 1'b0, 4'h0, '0);
    cyc(); inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h1c00_0100;
    exp_addr(ID_DATA, 32'h1c00_0100, 1'b0, 4'h0, '0);
    cyc(); data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h1c00_0200;
    @(negedge clk);
    chk1("t28_full_mem_req", mem_req, 1'b0);
    chk1("t28_full_inst_addr_ok", inst_addr_ok, 1'b0);
    cyc(); mem_data_ok = 1'b1; mem_rdata = 32'h0000_00a1;
    exp_data(ID_INST, 32'h0000_00a1);
    @(negedge clk);
    chk1("t28_full_pop_mem_req", mem_req, 1'b0);
    cyc(); mem_rdata = 32'h0000_00b2;
    exp_data(ID_DATA, 32'h0000_00b2);
    exp_addr(ID_INST, 32'h1c00_0200, 1'b0, 4'h0, '0);
    @(negedge clk);
    chk1("t28_resume_mem_req", mem_req, 1'b1);
    cyc(); inst_req = 1'b0; mem_rdata = 32'h0000_00c3;
    exp_data(ID_INST, 32'h0000_00c3);
    cyc(); mem_rdata = 32'h0000_00d4;
    @(negedge clk);
    chk1("t28_empty_data_ok", inst_data_ok | data_data_ok, 1'b0);
    cyc(); clr_in();

    // Starvation: data wins 4 cycles, inst forced on the 5th, then counter is back at 0.
    inst_req = 1'b1; inst_addr = 32'h0000_5000; data_req = 1'b1; mem_addr_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_addr = 32'h0000_6000 + 32'(i * 4);
      win_inst = (i == 4);
      if (win_inst) exp_addr(ID_INST, 32'h0000_5000, 1'b0, 4'h0, '0);
      else          exp_addr(ID_DATA, data_addr, 1'b0, 4'h0, '0);
      if (i >= 1) begin
        mem_data_ok = 1'b1;
        mem_rdata = 32'h0000_0100 + 32'(i);
        exp_data((i == 5) ? ID_INST : ID_DATA, mem_rdata);
      end
      @(negedge clk);
      chk1("t26_inst_win", inst_addr_ok, win_inst);
      chk1("t26_data_win", data_addr_ok, !win_inst);
      cyc();
    end
    clr_in(); mem_data_ok = 1'b1; mem_rdata = 32'h0000_01ff;
    exp_data(ID_DATA, 32'h0000_01ff);
    cyc(); clr_in();

    // Reset with two outstanding: later data_ok is ignored, port recovers.
    inst_req = 1'b1; inst_addr = 32'h0000_7000; mem_addr_ok = 1'b1;
    exp_addr(ID_INST, 32'h0000_7000, 1'b0, 4'h0, '0);
    cyc(); inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h0000_8000;
    exp_addr(ID_DATA, 32'h0000_8000, 1'b0, 4'h0, '0);
    cyc(); data_req = 1'b0; inst_req = 1'b1; resetn = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h0000_0099;
    @(negedge clk);
    chk1("t29_rst_mem_req", mem_req, 1'b0);
    chk("t29_rst_data_ok", 32'({inst_data_ok, data_data_ok}), '0);
    cyc(); resetn = 1'b1; inst_req = 1'b0;
    @(negedge clk);
    chk("t29_post_rst_data_ok", 32'({inst_data_ok, data_data_ok}), '0);
    cyc(); clr_in();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'h3;
    data_addr = 32'h0000_9000; data_wdata = 32'h0000_cafe; mem_addr_ok = 1'b1;
    exp_addr(ID_DATA, 32'h0000_9000, 1'b1, 4'h3, 32'h0000_cafe);
    cyc(); clr_in(); mem_data_ok = 1'b1; mem_rdata = 32'h0000_0042;
    exp_data(ID_DATA, 32'h0000_0042);
    cyc(); clr_in();
    cyc();

    chk("addr_q_drained", 32'(addr_q.size()), '0);
    chk("data_q_drained", 32'(data_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address/data width.
REQ-002 SHALL have parameter OUT_DEPTH, default 2, maximum outstanding transactions (power of two, >=2).
REQ-003 SHALL have parameter STARVE_MAX, default 4, consecutive lost arbitration cycles before inst is forced.
REQ-004 SHALL have ports: clk input 1 clock; resetn input 1 reset, asynchronous, active-low.
REQ-005 SHALL have inst port: inst_req in 1; inst_addr in ADDR_W; inst_addr_ok out 1; inst_data_ok out 1; inst_rdata out ADDR_W (read-only requester).
REQ-006 SHALL have data port: data_req in 1; data_wr in 1; data_wstrb in 4; data_addr in ADDR_W; data_wdata in ADDR_W; data_addr_ok out 1; data_data_ok out 1; data_rdata out ADDR_W.
REQ-007 SHALL have memory port: mem_req out 1; mem_wr out 1; mem_wstrb out 4; mem_addr out ADDR_W; mem_wdata out ADDR_W; mem_addr_ok in 1; mem_data_ok in 1; mem_rdata in ADDR_W.

Function
REQ-008 SHALL share one split-transaction memory port (address phase: req/addr_ok; data phase: data_ok) between inst and data requesters.
REQ-009 SHALL choose the winner combinationally each cycle: locked owner if lock set; else inst if starve count == STARVE_MAX; else data if data_req; else inst if inst_req; else none.
REQ-010 SHALL drive mem_req = winner exists AND outstanding count < OUT_DEPTH; mem_wr/mem_wstrb/mem_addr/mem_wdata from winner; inst grants drive mem_wr=0, mem_wstrb=0.
REQ-011 SHALL assert winner's addr_ok = mem_req AND mem_addr_ok; loser's addr_ok = 0; no added address-phase latency.
REQ-012 SHALL set lock with owner = winner when mem_req=1 and mem_addr_ok=0; clear lock on the address handshake; mem_* fields stay stable while locked.
REQ-013 SHALL push winner ID into an in-order ID FIFO on each address handshake (mem_req AND mem_addr_ok).
REQ-014 SHALL on mem_data_ok with FIFO non-empty pop head and assert inst_data_ok or data_data_ok (per head ID) in that same cycle; both rdata outputs = mem_rdata.
REQ-015 SHALL ignore mem_data_ok when FIFO empty: no data_ok, no state change.
REQ-016 SHALL allow push and pop in the same cycle when not full; count unchanged.
REQ-017 SHALL block new grants when full (count == OUT_DEPTH) even if a pop occurs that cycle; grant resumes next cycle.
REQ-018 SHALL keep starve counter: +1 (saturating at STARVE_MAX) each cycle inst_req=1 without inst handshake; clear on inst handshake or inst_req=0.
REQ-019 SHALL keep at most one data_ok per cycle; never assert inst_data_ok and data_data_ok together.

Reset
REQ-020 SHALL on resetn=0 asynchronously clear FIFO (count 0), lock, owner, starve counter.
REQ-021 SHALL hold mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok at 0 during reset; data outputs 0.
REQ-022 SHALL drop outstanding transactions on reset mid-operation; later mem_data_ok handled per REQ-015.

Structure
REQ-023 SHALL place requester ID encoding (ID_INST=0, ID_DATA=1) and default parameter constants in the shared CPU package/header.
REQ-024 SHALL implement the outstanding-ID queue as sub-module req_id_fifo (depth OUT_DEPTH, width 1, push/pop/full/empty/count).

Verification
REQ-025 SHALL cover: simultaneous inst_req and data_req, mem_addr_ok=1 -> data_addr_ok=1, inst_addr_ok=0, mem_addr=data_addr.
REQ-026 SHALL cover: data_req held high 4 cycles with inst_req high, STARVE_MAX=4 -> 5th cycle inst wins, counter returns to 0.
REQ-027 SHALL cover: inst grant, mem_addr_ok=0 for 3 cycles while data_req rises -> mem_addr stays inst_addr, data_addr_ok=0 until inst handshake.
REQ-028 SHALL cover: inst addr 0x1c000000 then data read 0x1c000100 accepted, mem_data_ok twice -> inst_data_ok first, data_data_ok second; third request blocked (mem_req=0) until first pop.
REQ-029 SHALL cover: resetn pulled low with 2 outstanding, then mem_data_ok -> no data_ok asserted, mem_req=0 during reset.
REQ-030 SHALL check by assertion: no data_ok without outstanding entry; both data_ok never high together.
